// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, LLU results queue in a FIFO.
// Optional pending-rd scoreboard on llu_busy when WB_SCOREBOARD_EN is defined.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        llu_valid,
  output logic        llu_ready,
  input  logic [4:0]  llu_rd,
  input  logic [31:0] llu_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic [31:0] llu_busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]    LIMIT   = 8'(STARVE_LIMIT);

  logic [4:0]    mem_rd   [FIFO_DEPTH];
  logic [31:0]   mem_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    starve_cnt;
  logic [7:0]    starve_next;
  logic          stall_next;
  logic          full;
  logic          empty;
  logic          slot_busy;
  logic          pop;
  logic          push;

  // Handshake: an LLU result transfers on an edge where llu_valid && llu_ready;
  // llu_ready depends only on the registered occupancy, never on this cycle's pop.
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign llu_ready = !full;
  assign slot_busy = RegWriteW && (RdW != 5'd0);
  assign pop       = !slot_busy && !empty;
  assign push      = llu_valid && !full && (llu_rd != 5'd0);

  always_comb begin
    starve_next = starve_cnt;
    if (pop || empty) begin
      starve_next = '0;
    end else if (starve_cnt != LIMIT) begin
      starve_next = starve_cnt + 8'd1;
    end
  end

  // Fire on the edge the counter reaches the limit; re-fire if the bubble was not honoured.
  assign stall_next = (starve_next == LIMIT) && ((starve_cnt != LIMIT) || stall_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      stall_req  <= 1'b0;
      starve_cnt <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (slot_busy) begin
        rf_we    <= 1'b1;
        rf_rd    <= RdW;
        rf_wdata <= ResultW;
      end else if (pop) begin
        rf_we    <= 1'b1;
        rf_rd    <= mem_rd[rd_ptr];
        rf_wdata <= mem_data[rd_ptr];
      end else begin
        rf_we    <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      starve_cnt <= starve_next;
      stall_req  <= stall_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= llu_rd;
      mem_data[wr_ptr] <= llu_data;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q;
  logic [31:0] busy_next;

  // Clear for the popped rd first so a same-edge enqueue of that rd wins.
  always_comb begin
    busy_next = busy_q;
    if (pop) begin
      busy_next[mem_rd[rd_ptr]] = 1'b0;
    end
    if (push) begin
      busy_next[llu_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign llu_busy = busy_q;
`else
  assign llu_busy = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        llu_valid;
  logic        llu_ready;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [31:0] llu_busy;

  int checks = 0;
  int failures = 0;

  // Reference model: pending LLU results as {rd, data}, plus expected registered outputs.
  logic [36:0] exp_q[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;
  logic        m_stall;
  int          m_wait;
  logic [31:0] m_busy;

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .llu_valid(llu_valid), .llu_ready(llu_ready), .llu_rd(llu_rd), .llu_data(llu_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .stall_req(stall_req), .llu_busy(llu_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_busy();
`ifdef WB_SCOREBOARD_EN
    return m_busy;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_we = 1'b0; m_rd = '0; m_wdata = '0; m_stall = 1'b0; m_wait = 0; m_busy = '0;
  endtask

  // One clock edge in the model, using the inputs currently applied.
  task automatic model_edge();
    int n;
    int prev_wait;
    logic slot, pop, push;
    logic [36:0] head;
    n = exp_q.size();
    slot = RegWriteW && (RdW != 0);
    pop = !slot && (n > 0);
    push = llu_valid && (n < DEPTH) && (llu_rd != 0);
    if (slot) begin
      m_we = 1'b1; m_rd = RdW; m_wdata = ResultW;
    end else if (pop) begin
      head = exp_q.pop_front();
      m_we = 1'b1; m_rd = head[36:32]; m_wdata = head[31:0];
      m_busy[head[36:32]] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (push) begin
      exp_q.push_back({llu_rd, llu_data});
      m_busy[llu_rd] = 1'b1;
    end
    prev_wait = m_wait;
    if (pop || n == 0) m_wait = 0;
    else if (m_wait < LIMIT) m_wait = m_wait + 1;
    m_stall = (m_wait == LIMIT) && (prev_wait != LIMIT || m_stall);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
  endtask

  task automatic drain();
    set_idle();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || m_stall); i++) step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    #1;
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0 || stall_req !== 1'b0 || llu_busy !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: we=%0b rd=%0d wdata=%h stall=%0b busy=%h, want all 0",
               rf_we, rf_rd, rf_wdata, stall_req, llu_busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (llu_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: llu_ready=%0b want 1", llu_ready);
    end
  endtask

  task automatic test_pipeline_write();
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hA5A5A5A5;
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL pipe_write: we=%0b rd=%0d wdata=%h want 1/5/a5a5a5a5", rf_we, rf_rd, rf_wdata);
    end
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0;
    step();
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL pipe_hold: we=%0b rd=%0d wdata=%h want 0/5/a5a5a5a5", rf_we, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_llu_order();
    llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'h11;
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL order_first_edge: rf_we=%0b want 0", rf_we);
    end
    llu_rd = 5'd9; llu_data = 32'h22;
    step();
    llu_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h11) begin
      failures++;
      $display("FAIL order_w1: we=%0b rd=%0d wdata=%h want 1/7/11", rf_we, rf_rd, rf_wdata);
    end
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h22) begin
      failures++;
      $display("FAIL order_w2: we=%0b rd=%0d wdata=%h want 1/9/22", rf_we, rf_rd, rf_wdata);
    end
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL order_done: rf_we=%0b want 0", rf_we);
    end
  endtask

  task automatic test_fifo_full();
    RegWriteW = 1'b1; RdW = 5'd6; ResultW = 32'h66;
    llu_valid = 1'b1; llu_rd = 5'd10; llu_data = 32'h100;
    step();
    llu_rd = 5'd11; llu_data = 32'h200;
    step();
    llu_rd = 5'd12; llu_data = 32'h300;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (llu_ready !== 1'b0) begin
        failures++;
        $display("FAIL full_ready: llu_ready=%0b want 0", llu_ready);
      end
      step();
    end
    llu_valid = 1'b0; RegWriteW = 1'b0; RdW = 5'd0;
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== 32'h100) begin
      failures++;
      $display("FAIL full_drain1: we=%0b rd=%0d wdata=%h want 1/10/100", rf_we, rf_rd, rf_wdata);
    end
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd11 || rf_wdata !== 32'h200) begin
      failures++;
      $display("FAIL full_drain2: we=%0b rd=%0d wdata=%h want 1/11/200", rf_we, rf_rd, rf_wdata);
    end
    step();
    checks++;
    if (rf_we !== 1'b0 || llu_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_no_third: we=%0b ready=%0b want 0/1", rf_we, llu_ready);
    end
  endtask

  task automatic test_starvation();
    RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h2;
    llu_valid = 1'b1; llu_rd = 5'd4; llu_data = 32'h44;
    step();
    llu_valid = 1'b0;
    for (int i = 1; i <= LIMIT; i++) begin
      ResultW = 32'(i);
      step();
      checks++;
      if (stall_req !== (i == LIMIT)) begin
        failures++;
        $display("FAIL starve_wait%0d: stall_req=%0b want %0b", i, stall_req, (i == LIMIT));
      end
    end
    RegWriteW = 1'b0; RdW = 5'd0;
    step();
    checks++;
    if (stall_req !== 1'b0 || rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'h44) begin
      failures++;
      $display("FAIL starve_pop: stall=%0b we=%0b rd=%0d wdata=%h want 0/1/4/44",
               stall_req, rf_we, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_violation();
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h33;
    llu_valid = 1'b1; llu_rd = 5'd8; llu_data = 32'h88;
    step();
    llu_valid = 1'b0;
    for (int i = 0; i < LIMIT; i++) step();
    ResultW = 32'h77;
    step();
    checks++;
    if (stall_req !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h77) begin
      failures++;
      $display("FAIL violation_refire: stall=%0b rd=%0d wdata=%h want 1/3/77", stall_req, rf_rd, rf_wdata);
    end
    RegWriteW = 1'b0; RdW = 5'd0;
    step();
    checks++;
    if (stall_req !== 1'b0 || rf_rd !== 5'd8 || rf_wdata !== 32'h88) begin
      failures++;
      $display("FAIL violation_pop: stall=%0b rd=%0d wdata=%h want 0/8/88", stall_req, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_rd_zero();
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hBAD0;
    llu_valid = 1'b1; llu_rd = 5'd0; llu_data = 32'hBAD1;
    step();
    set_idle();
    checks++;
    if (rf_we !== 1'b0 || llu_ready !== 1'b1 || llu_busy !== 32'd0) begin
      failures++;
      $display("FAIL rd_zero: we=%0b ready=%0b busy=%h want 0/1/0", rf_we, llu_ready, llu_busy);
    end
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL rd_zero_nowrite: rf_we=%0b want 0", rf_we);
    end
  endtask

  task automatic test_scoreboard();
    logic [31:0] want;
    RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h1;
    llu_valid = 1'b1; llu_rd = 5'd3; llu_data = 32'h3333;
    step();
    llu_valid = 1'b0;
`ifdef WB_SCOREBOARD_EN
    want = 32'h8;
`else
    want = 32'h0;
`endif
    checks++;
    if (llu_busy !== want) begin
      failures++;
      $display("FAIL sb_set: llu_busy=%h want %h", llu_busy, want);
    end
    RegWriteW = 1'b0; RdW = 5'd0;
    step();
    checks++;
    if (llu_busy !== 32'h0 || rf_rd !== 5'd3) begin
      failures++;
      $display("FAIL sb_clear: llu_busy=%h rf_rd=%0d want 0/3", llu_busy, rf_rd);
    end
  endtask

  task automatic test_random();
    int bias;
    for (int i = 0; i < 3000; i++) begin
      bias = ((i / 300) % 2 == 1) ? 97 : 45;
      RegWriteW = ($urandom_range(0, 99) < bias);
      if (stall_req && $urandom_range(0, 19) != 0) RegWriteW = 1'b0;
      RdW = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ResultW = $urandom;
      llu_valid = ($urandom_range(0, 99) < 40);
      llu_rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      llu_data = $urandom;
      step();
      checks++;
      if (rf_we !== m_we || rf_rd !== m_rd || rf_wdata !== m_wdata || stall_req !== m_stall ||
          llu_ready !== (exp_q.size() < DEPTH) || llu_busy !== exp_busy()) begin
        failures++;
        $display("FAIL random_cycle%0d: we=%0b rd=%0d wdata=%h stall=%0b ready=%0b busy=%h want %0b/%0d/%h/%0b/%0b/%h",
                 i, rf_we, rf_rd, rf_wdata, stall_req, llu_ready, llu_busy,
                 m_we, m_rd, m_wdata, m_stall, (exp_q.size() < DEPTH), exp_busy());
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'hDEAD0001;
    llu_valid = 1'b1; llu_rd = 5'd13; llu_data = 32'h1313;
    step();
    llu_rd = 5'd14; llu_data = 32'h1414;
    step();
    set_idle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0 || stall_req !== 1'b0 || llu_busy !== 32'd0) begin
      failures++;
      $display("FAIL reset_async: we=%0b rd=%0d wdata=%h stall=%0b busy=%h want all 0",
               rf_we, rf_rd, rf_wdata, stall_req, llu_busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step();
    checks++;
    if (llu_ready !== 1'b1 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard: ready=%0b we=%0b want 1/0", llu_ready, rf_we);
    end
  endtask

  initial begin
    test_reset();
    test_pipeline_write();
    drain();
    test_llu_order();
    drain();
    test_fifo_full();
    drain();
    test_starvation();
    drain();
    test_violation();
    drain();
    test_rd_zero();
    drain();
    test_scoreboard();
    drain();
    test_random();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
